// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per clock.
// start/done handshake; err flags any input digit above 9.
module bcd_to_bin_seq #(
   parameter int N_DIGITS = 3,
   parameter int BIN_W    = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*N_DIGITS-1:0] bcd,
   output logic [BIN_W-1:0]      bin,
   output logic                  done,
   output logic                  busy,
   output logic                  err
);

   localparam int BCD_W = 4 * N_DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [BCD_W-1:0]   work;
   logic [BIN_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               bad;

   logic               in_bad;
   logic [BCD_W-1:0]   work_sh;
   logic [BCD_W-1:0]   work_nx;
   logic [BIN_W-1:0]   acc_sh;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      in_bad = 1'b0;
      for (int d = 0; d < N_DIGITS; d++) begin
         if (bcd[4*d +: 4] > 4'd9) in_bad = 1'b1;
      end
   end

   // One iteration: shift {work, acc} right, then correct each digit that reached 8 or more.
   always_comb begin
      acc_sh  = {work[0], acc[BIN_W-1:1]};
      work_sh = work >> 1;
      work_nx = work_sh;
      for (int d = 0; d < N_DIGITS; d++) begin
         if (work_sh[4*d +: 4] >= 4'd8) work_nx[4*d +: 4] = work_sh[4*d +: 4] - 4'd3;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         work  <= '0;
         acc   <= '0;
         cnt   <= '0;
         bad   <= 1'b0;
         bin   <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  work  <= bcd;
                  acc   <= '0;
                  cnt   <= CNT_W'(BIN_W);
                  bad   <= in_bad;
                  busy  <= 1'b1;
                  state <= CONV;
               end
            end
            CONV: begin
               if (bad) begin
                  // Invalid input skips iteration entirely and reports a zero result.
                  bin   <= '0;
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  work <= work_nx;
                  acc  <= acc_sh;
                  cnt  <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     bin   <= acc_sh;
                     err   <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench for bcd_to_bin_seq: timeline-level reference model compared
// every cycle, plus directed, random and exhaustive stimulus.
module tb_bcd_to_bin_seq;

   localparam int N_DIGITS = 3;
   localparam int BIN_W    = 10;
   localparam int BCD_W    = 4 * N_DIGITS;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [BCD_W-1:0]  bcd;
   logic [BIN_W-1:0]  bin;
   logic              done;
   logic              busy;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_to_bin_seq #(.N_DIGITS(N_DIGITS), .BIN_W(BIN_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .bcd   (bcd),
      .bin   (bin),
      .done  (done),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Decimal meaning of a packed BCD word, and whether any digit is out of range.
   function automatic int bcd_value(input logic [BCD_W-1:0] b);
      int v = 0;
      for (int d = N_DIGITS - 1; d >= 0; d--) v = v * 10 + int'(b[4*d +: 4]);
      return v;
   endfunction

   function automatic bit bcd_bad(input logic [BCD_W-1:0] b);
      bit r = 1'b0;
      for (int d = 0; d < N_DIGITS; d++) if (b[4*d +: 4] > 4'd9) r = 1'b1;
      return r;
   endfunction

   function automatic logic [BCD_W-1:0] to_bcd(input int v);
      logic [BCD_W-1:0] r;
      int x = v;
      for (int d = 0; d < N_DIGITS; d++) begin
         r[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Reference model: phase 0 idle, 1 converting (m_left edges to go), 2 result presented.
   int               m_phase = 0;
   int               m_left  = 0;
   int               m_val   = 0;
   bit               m_err_nx = 1'b0;
   logic [BIN_W-1:0] m_bin   = '0;
   bit               m_err   = 1'b0;
   bit               m_done  = 1'b0;
   bit               m_live  = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0;
         m_bin   <= '0;
         m_err   <= 1'b0;
         m_done  <= 1'b0;
         m_live  <= 1'b1;
      end else if (m_live) begin
         case (m_phase)
            0: if (start) begin
               m_phase  <= 1;
               m_left   <= bcd_bad(bcd) ? 1 : BIN_W;
               m_val    <= bcd_bad(bcd) ? 0 : bcd_value(bcd);
               m_err_nx <= bcd_bad(bcd);
            end
            1: begin
               if (m_left == 1) begin
                  m_phase <= 2;
                  m_done  <= 1'b1;
                  m_bin   <= BIN_W'(m_val);
                  m_err   <= m_err_nx;
               end else begin
                  m_left <= m_left - 1;
               end
            end
            default: begin
               m_phase <= 0;
               m_done  <= 1'b0;
            end
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("cyc_bin",  32'(bin),  32'(m_bin));
         check("cyc_done", 32'(done), 32'(m_done));
         check("cyc_busy", 32'(busy), 32'(m_phase != 0));
         check("cyc_err",  32'(err),  32'(m_err));
         if (done === 1'b1 && err === 1'b0) check("w_zero", 32'(dut.work), 32'd0);
      end
   end

   task automatic run(input logic [BCD_W-1:0] code, input int exp_bin, input bit exp_err,
                      input int exp_lat, input string name);
      int edges;
      @(negedge clk);
      start = 1'b1;
      bcd   = code;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      start = 1'b0;
      bcd   = BCD_W'($urandom);
      while (done !== 1'b1 && edges < 40) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      check({name, "_lat"}, 32'(edges), 32'(exp_lat));
      check({name, "_bin"}, 32'(bin),   32'(exp_bin));
      check({name, "_err"}, 32'(err),   32'(exp_err));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      int pulses;
      int gap;
      logic [BIN_W-1:0] seen;

      rst   = 1'b1;
      start = 1'b0;
      bcd   = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_bin",  32'(bin),  32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err",  32'(err),  32'd0);
      rst = 1'b0;

      // Pin the model's arithmetic to hand-computed values.
      check("pin_999", 32'(bcd_value(12'h999)), 32'd999);
      check("pin_255", 32'(bcd_value(12'h255)), 32'd255);
      check("pin_bad", 32'(bcd_bad(12'h1A3)),   32'd1);
      check("pin_enc", 32'(to_bcd(407)),        32'h407);

      run(12'h000, 0,   1'b0, 11, "zero");
      run(12'h999, 999, 1'b0, 11, "max");
      run(12'h255, 255, 1'b0, 11, "mid");
      run(12'h100, 100, 1'b0, 11, "hund");
      run(12'h1A3, 0,   1'b1, 2,  "inval");
      run(12'h042, 42,  1'b0, 11, "after_inval");

      // start pulsed during conversion is ignored.
      @(negedge clk);
      start = 1'b1;
      bcd   = 12'h999;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      bcd   = 12'h777;
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      pulses = 0;
      seen   = '0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) begin
            pulses++;
            seen = bin;
         end
         @(posedge clk);
         @(negedge clk);
      end
      check("ign_pulses", 32'(pulses), 32'd1);
      check("ign_bin",    32'(seen),   32'd999);

      // Reset mid-conversion abandons it.
      start = 1'b1;
      bcd   = 12'h999;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_bin",  32'(bin),  32'd0);
      rst    = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         if (done === 1'b1) pulses++;
         @(posedge clk);
         @(negedge clk);
      end
      check("abort_pulses", 32'(pulses), 32'd0);
      run(12'h123, 123, 1'b0, 11, "post_abort");

      // Random traffic: start, bcd and occasional reset, checked by the model each cycle.
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         bcd   = ($urandom_range(0, 9) < 7) ? to_bcd($urandom_range(0, 999)) : BCD_W'($urandom);
         rst   = ($urandom_range(0, 79) == 0);
      end
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      repeat (15) @(posedge clk);

      // Exhaustive valid codes, start held high back-to-back.
      @(negedge clk);
      bcd   = to_bcd(0);
      start = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         gap = 0;
         do begin
            @(posedge clk);
            @(negedge clk);
            gap++;
         end while (done !== 1'b1 && gap < 40);
         check("exh_bin", 32'(bin), 32'(i));
         check("exh_gap", 32'(gap), (i == 0) ? 32'd11 : 32'd12);
         if (gap >= 40) break;
         if (i < 999) bcd = to_bcd(i + 1);
      end
      start = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
